// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU and a debug/loader port.
// The CPU owns memory by default. A pending debug request waits behind CPU
// traffic for at most MAX_WAIT cycles, then takes memory for a burst of up
// to BURST_MAX beats before control returns to the CPU.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   CPU_OWN | CPU drives memory; debug requests count wait cycles
//   DBG_OWN | debug port drives memory; CPU is stalled if it requests
module dmem_arbiter #(
   parameter int MAX_WAIT  = 4,
   parameter int BURST_MAX = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dbg_req,
   input  logic        dbg_we,
   input  logic        dbg_last,
   input  logic [31:0] dbg_addr,
   input  logic [31:0] dbg_wdata,
   output logic        dbg_gnt,
   output logic [31:0] dbg_rdata,
   output logic        dbg_valid,
   output logic        dbg_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int BW = $clog2(BURST_MAX + 1);

   typedef enum logic {
      CPU_OWN = 1'b0,
      DBG_OWN = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [WW-1:0]   r_wait_cnt;
   logic [BW-1:0]   r_beat_cnt;
   logic [31:0]     r_dbg_rdata;
   logic            r_dbg_valid;
   logic            r_dbg_err;

   logic            w_dbg_aligned;
   logic            w_dbg_acc;
   logic            w_wait_full;
   logic            w_burst_end;
   logic            w_dbg_rd_ok;

   assign w_dbg_aligned = (dbg_addr[1:0] == 2'b00);
   assign w_dbg_acc     = (r_state == DBG_OWN) && dbg_req;
   assign w_wait_full   = (r_wait_cnt == WW'(MAX_WAIT));
   // The beat being accepted now is the BURST_MAX-th one.
   assign w_burst_end   = (r_beat_cnt == BW'(BURST_MAX - 1));
   assign w_dbg_rd_ok   = w_dbg_acc && !dbg_we && w_dbg_aligned;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= CPU_OWN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decision: CPU wins contention until the wait budget is spent.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         CPU_OWN: begin
            if (dbg_req && (!cpu_req || w_wait_full)) begin
               w_state_nxt = DBG_OWN;
            end
         end
         DBG_OWN: begin
            if (!dbg_req || dbg_last || w_burst_end) begin
               w_state_nxt = CPU_OWN;
            end
         end
         default: w_state_nxt = CPU_OWN;
      endcase
   end

   // Output mux: memory port follows the current owner.
   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = cpu_req && cpu_we;
      dbg_gnt   = 1'b0;
      cpu_stall = 1'b0;
      if (r_state == DBG_OWN) begin
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
         // Misaligned debug writes are dropped rather than corrupting memory.
         mem_we    = dbg_req && dbg_we && w_dbg_aligned;
         dbg_gnt   = 1'b1;
         cpu_stall = cpu_req;
      end
   end

   // Wait counter: counts cycles a debug request loses to the CPU, saturating.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wait_cnt <= '0;
      end else if (r_state == DBG_OWN || !dbg_req || w_state_nxt == DBG_OWN) begin
         r_wait_cnt <= '0;
      end else if (cpu_req && !w_wait_full) begin
         r_wait_cnt <= r_wait_cnt + WW'(1);
      end
   end

   // Beat counter: accepted beats in the current grant, zero outside a burst.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_beat_cnt <= '0;
      end else if (r_state == CPU_OWN || w_state_nxt == CPU_OWN) begin
         r_beat_cnt <= '0;
      end else if (w_dbg_acc) begin
         r_beat_cnt <= r_beat_cnt + BW'(1);
      end
   end

   // Debug response: one-cycle valid/err flags; read data held until the next read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dbg_rdata <= '0;
         r_dbg_valid <= 1'b0;
         r_dbg_err   <= 1'b0;
      end else begin
         r_dbg_valid <= w_dbg_rd_ok;
         r_dbg_err   <= w_dbg_acc && !w_dbg_aligned;
         if (w_dbg_rd_ok) begin
            r_dbg_rdata <= mem_rdata;
         end
      end
   end

   assign cpu_rdata = mem_rdata;
   assign dbg_rdata = r_dbg_rdata;
   assign dbg_valid = r_dbg_valid;
   assign dbg_err   = r_dbg_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: attached memory, behavioural ownership model,
// per-cycle compare, directed scenarios and a randomized phase.
module tb_dmem_arbiter;

   localparam int MAX_WAIT  = 4;
   localparam int BURST_MAX = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall;
   logic        dbg_req, dbg_we, dbg_last;
   logic [31:0] dbg_addr, dbg_wdata;
   logic        dbg_gnt;
   logic [31:0] dbg_rdata;
   logic        dbg_valid, dbg_err;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int n_cmp = 0;
   int n_bad = 0;

   dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .BURST_MAX(BURST_MAX)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_last(dbg_last),
      .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_valid(dbg_valid), .dbg_err(dbg_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Physical memory seen by the DUT: synchronous write, combinational read.
   bit [31:0] mem [64];
   assign mem_rdata = mem[mem_addr[7:2]];
   always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

   // Behavioural model: who owns memory, how long debug has waited, beats granted.
   bit          m_dbg   = 1'b0;
   int          m_wait  = 0;
   int          m_beats = 0;
   logic [31:0] m_rdata = '0;
   bit          m_valid = 1'b0;
   bit          m_err   = 1'b0;
   bit [31:0]   ref_mem [64];

   logic        exp_gnt, exp_stall, exp_we;
   logic [31:0] exp_addr, exp_wdata;

   always_comb begin
      exp_gnt   = m_dbg;
      exp_stall = m_dbg && cpu_req;
      exp_addr  = m_dbg ? dbg_addr  : cpu_addr;
      exp_wdata = m_dbg ? dbg_wdata : cpu_wdata;
      exp_we    = m_dbg ? (dbg_req && dbg_we && dbg_addr[1:0] == 2'b00) : (cpu_req && cpu_we);
   end

   always @(posedge clk) if (exp_we) ref_mem[exp_addr[7:2]] <= exp_wdata;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_dbg <= 1'b0; m_wait <= 0; m_beats <= 0;
         m_rdata <= '0; m_valid <= 1'b0; m_err <= 1'b0;
      end else if (!m_dbg) begin
         m_valid <= 1'b0;
         m_err   <= 1'b0;
         if (dbg_req && (!cpu_req || m_wait == MAX_WAIT)) begin
            m_dbg <= 1'b1; m_wait <= 0; m_beats <= 0;
         end else if (!dbg_req) begin
            m_wait <= 0;
         end else begin
            m_wait <= (m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1;
         end
      end else if (!dbg_req) begin
         m_dbg <= 1'b0; m_beats <= 0; m_valid <= 1'b0; m_err <= 1'b0;
      end else begin
         if (dbg_last || m_beats + 1 >= BURST_MAX) begin
            m_dbg <= 1'b0; m_beats <= 0;
         end else begin
            m_beats <= m_beats + 1;
         end
         m_err   <= (dbg_addr[1:0] != 2'b00);
         m_valid <= !dbg_we && dbg_addr[1:0] == 2'b00;
         if (!dbg_we && dbg_addr[1:0] == 2'b00) m_rdata <= ref_mem[dbg_addr[7:2]];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_compare();
      check("gnt",       {31'b0, dbg_gnt},   {31'b0, exp_gnt});
      check("stall",     {31'b0, cpu_stall}, {31'b0, exp_stall});
      check("mem_we",    {31'b0, mem_we},    {31'b0, exp_we});
      check("mem_addr",  mem_addr,  exp_addr);
      check("mem_wdata", mem_wdata, exp_wdata);
      check("cpu_rdata", cpu_rdata, ref_mem[exp_addr[7:2]]);
      check("dbg_valid", {31'b0, dbg_valid}, {31'b0, m_valid});
      check("dbg_err",   {31'b0, dbg_err},   {31'b0, m_err});
      check("dbg_rdata", dbg_rdata, m_rdata);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_last = 0; dbg_addr = '0; dbg_wdata = '0;
   endtask

   initial begin
      int first_gnt;
      int acc;
      int vcnt;
      bit seen;
      bit hit;

      idle_inputs();
      reset = 1'b1;
      fork
         forever begin
            @(negedge clk);
            model_compare();
         end
      join_none
      #2 reset = 1'b0;

      // Reset: debug can not be granted; CPU writes still pass through.
      cpu_req = 1; cpu_we = 1; dbg_req = 1; dbg_we = 1;
      @(negedge clk);
      check("rst_gnt",   {31'b0, dbg_gnt},   32'd0);
      check("rst_stall", {31'b0, cpu_stall}, 32'd0);
      check("rst_we",    {31'b0, mem_we},    32'd1);
      check("rst_valid", {31'b0, dbg_valid}, 32'd0);
      check("rst_err",   {31'b0, dbg_err},   32'd0);
      check("rst_rdata", dbg_rdata,          32'd0);
      tick();
      reset = 1'b1;
      idle_inputs();
      tick();

      // CPU only: write then read back.
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h0000_00AB;
      @(negedge clk);
      check("cpu_wr_stall", {31'b0, cpu_stall}, 32'd0);
      tick();
      cpu_we = 0;
      @(negedge clk);
      check("cpu_rd_data",  cpu_rdata, 32'h0000_00AB);
      check("cpu_rd_stall", {31'b0, cpu_stall}, 32'd0);
      tick();
      idle_inputs();

      // Idle CPU: single-beat debug write.
      dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h1234_5678; dbg_last = 1;
      @(negedge clk);
      check("idle_gnt0", {31'b0, dbg_gnt}, 32'd0);
      tick();
      @(negedge clk);
      check("idle_gnt1", {31'b0, dbg_gnt}, 32'd1);
      check("idle_we",   {31'b0, mem_we},  32'd1);
      tick();
      dbg_req = 0;
      @(negedge clk);
      check("idle_back", {31'b0, dbg_gnt}, 32'd0);
      tick();
      idle_inputs();
      cpu_req = 1; cpu_addr = 32'h20;
      @(negedge clk);
      check("idle_wr_mem", cpu_rdata, 32'h1234_5678);
      tick();
      idle_inputs();
      tick();

      // Contention: grant arrives on cycle MAX_WAIT+2.
      cpu_req = 1; cpu_addr = 32'h10; dbg_req = 1; dbg_addr = 32'h10;
      first_gnt = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (dbg_gnt && first_gnt == 0) first_gnt = k;
         if (dbg_gnt) check("cont_stall", {31'b0, cpu_stall}, 32'd1);
         tick();
      end
      check("cont_latency", first_gnt, 32'd6);
      idle_inputs();
      tick(); tick(); tick();

      // Burst limit: debug keeps reading without dbg_last.
      dbg_req = 1; dbg_addr = 32'h40;
      acc = 0; vcnt = 0; seen = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (dbg_valid) vcnt++;
         hit = dbg_gnt && dbg_req;
         if (hit) acc++;
         if (dbg_gnt) seen = 1;
         else if (seen) begin
            check("burst_ret", {31'b0, dbg_gnt}, 32'd0);
            break;
         end
         tick();
         if (hit) dbg_addr = dbg_addr + 32'd4;
      end
      check("burst_beats", acc, BURST_MAX);
      check("burst_valid", vcnt, BURST_MAX);
      tick();
      idle_inputs();
      tick(); tick(); tick();
      @(negedge clk);
      check("burst_cpu_own", {31'b0, dbg_gnt}, 32'd0);
      tick();

      // Misaligned debug write.
      dbg_req = 1; dbg_we = 1; dbg_addr = 32'h22; dbg_wdata = 32'hDEAD_BEEF; dbg_last = 1;
      tick();
      @(negedge clk);
      check("mis_gnt", {31'b0, dbg_gnt}, 32'd1);
      check("mis_we",  {31'b0, mem_we},  32'd0);
      tick();
      dbg_req = 0;
      @(negedge clk);
      check("mis_err1", {31'b0, dbg_err}, 32'd1);
      tick();
      @(negedge clk);
      check("mis_err0", {31'b0, dbg_err}, 32'd0);
      tick();
      idle_inputs();
      cpu_req = 1; cpu_addr = 32'h20;
      @(negedge clk);
      check("mis_mem", cpu_rdata, 32'h1234_5678);
      tick();
      idle_inputs();
      tick();

      // Reset during beat 3 of a write burst.
      dbg_req = 1; dbg_we = 1; dbg_addr = 32'h80; dbg_wdata = 32'hA000_0001;
      tick();
      tick();
      dbg_addr = 32'h84; dbg_wdata = 32'hA000_0002;
      tick();
      dbg_addr = 32'h88; dbg_wdata = 32'hA000_0003;
      reset = 1'b0;
      #1;
      check("mid_rst_gnt", {31'b0, dbg_gnt}, 32'd0);
      check("mid_rst_we",  {31'b0, mem_we},  32'd0);
      tick();
      reset = 1'b1;
      @(negedge clk);
      check("mid_rel_gnt", {31'b0, dbg_gnt}, 32'd0);
      tick();
      idle_inputs();
      tick(); tick();
      cpu_req = 1; cpu_addr = 32'h88;
      @(negedge clk);
      check("mid_beat3", cpu_rdata, 32'd0);
      tick();
      cpu_addr = 32'h84;
      @(negedge clk);
      check("mid_beat2", cpu_rdata, 32'hA000_0002);
      tick();
      idle_inputs();
      tick();

      // Randomized traffic, including occasional resets.
      for (int k = 0; k < 2000; k++) begin
         cpu_req   = 1'($urandom_range(0, 1));
         cpu_we    = 1'($urandom_range(0, 1));
         cpu_addr  = {24'h0, 8'($urandom)};
         cpu_wdata = $urandom;
         if ($urandom_range(0, 3) == 0) dbg_req = ~dbg_req;
         dbg_we    = 1'($urandom_range(0, 1));
         dbg_last  = ($urandom_range(0, 3) == 0);
         dbg_addr  = {24'h0, 6'($urandom), ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00};
         dbg_wdata = $urandom;
         reset     = ($urandom_range(0, 199) != 0);
         tick();
      end
      reset = 1'b1;
      idle_inputs();
      tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
